// File: rtl/switch_debounce_port_if.sv
// CPU-side register bus for the switch debounce port.
// The tri-state read data stays a plain port on the block.
interface switch_debounce_port_if;
    logic        isCS;
    logic        isW;
    logic [1:0]  addr;
    logic [15:0] dR;

    modport master (output isCS, output isW, output addr, output dR);
    modport slave  (input  isCS, input  isW, input  addr, input  dR);
endinterface

// File: rtl/switch_debounce_port.sv
// Debounced switch input port: per-bit synchronizer and debounce counter,
// with change flags, an interrupt mask, a transition counter and a registered irq.
module switch_debounce_port #(
    parameter int WIDTH     = 16,
    parameter int DB_CYCLES = 20000
) (
    input  logic                  clk,
    input  logic                  isReset,
    switch_debounce_port_if.slave bus,
    output wire  [15:0]           dW,
    input  logic [WIDTH-1:0]      data,
    output logic                  irq
);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_CHG  = 2'd1,
        REG_MASK = 2'd2,
        REG_CNT  = 2'd3
    } reg_sel_e;

    // A bit is accepted when its counter already holds DB_CYCLES-1 mismatches.
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] chg_q, chg_d, chg_clr;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] accept;
    logic [15:0]      db_cnt_q [WIDTH];
    logic [15:0]      db_cnt_d [WIDTH];
    logic [15:0]      cnt_q, cnt_d;
    logic [16:0]      cnt_sum;
    logic [4:0]       n_accept;
    logic             irq_q, irq_d;
    logic             wr_en, rd_en;
    reg_sel_e         sel;
    logic [15:0]      rd_data;

    assign sel   = reg_sel_e'(bus.addr);
    assign wr_en = bus.isCS & bus.isW & ~isReset;
    assign rd_en = bus.isCS & ~bus.isW & ~isReset;

    // NOTE: every variable gets its default before any branch, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            db_cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = s2_q[i];
                    accept[i]   = 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        n_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n_accept = n_accept + 5'(accept[i]);
        end
    end

    always_comb begin
        cnt_sum = {1'b0, cnt_q} + {12'd0, n_accept};
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        // A CNT write restarts the count from this edge's transitions.
        if (wr_en && sel == REG_CNT) begin
            cnt_d = {11'd0, n_accept};
        end

        chg_clr = (wr_en && sel == REG_CHG) ? bus.dR[WIDTH-1:0] : '0;
        chg_d   = (chg_q & ~chg_clr) | accept;

        mask_d  = (wr_en && sel == REG_MASK) ? bus.dR[WIDTH-1:0] : mask_q;
        irq_d   = |(chg_q & mask_q);
    end

    always_comb begin
        rd_data = '0;
        unique case (sel)
            REG_DATA: rd_data = 16'(stable_q);
            REG_CHG:  rd_data = 16'(chg_q);
            REG_MASK: rd_data = 16'(mask_q);
            REG_CNT:  rd_data = cnt_q;
        endcase
    end

    assign dW  = rd_en ? rd_data : 16'hzzzz;
    assign irq = irq_q;

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of its sources, independent of statement order.
    always_ff @(posedge clk) begin
        if (isReset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            chg_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            // NOTE: the counter array is small state, not a RAM, so it is
            // cleared element by element to discard any partial debounce.
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= data;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            chg_q    <= chg_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            db_cnt_q <= db_cnt_d;
        end
    end

endmodule

// File: tb/tb_switch_debounce_port.sv
// Self-checking bench: a window-based reference model predicts every bus read
// and irq; a negedge monitor pops the scoreboard and compares.
module tb_switch_debounce_port;

    localparam int WIDTH = 16;
    localparam int DB    = 4;

    logic             clk = 1'b0;
    logic             is_reset;
    logic [WIDTH-1:0] data;
    wire  [15:0]      dW;
    logic             irq;

    always #5 clk = ~clk;

    switch_debounce_port_if bus ();

    switch_debounce_port #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
        .clk     (clk),
        .isReset (is_reset),
        .bus     (bus),
        .dW      (dW),
        .data    (data),
        .irq     (irq)
    );

    typedef struct {
        logic        exp_z;
        logic [15:0] exp_val;
        logic        exp_irq;
        logic [1:0]  addr;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_stable = '0;
    logic [WIDTH-1:0] m_chg    = '0;
    logic [WIDTH-1:0] m_mask   = '0;
    logic [15:0]      m_cnt    = '0;
    logic             m_irq    = 1'b0;
    logic [WIDTH-1:0] raw_hist [$];
    logic [WIDTH-1:0] s2_hist  [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return 16'(m_stable);
            2'd1:    return 16'(m_chg);
            2'd2:    return 16'(m_mask);
            default: return m_cnt;
        endcase
    endfunction

    // A bit is accepted once the synchronized level (raw delayed two edges)
    // has differed from the stable level on each of the last DB edges.
    task automatic model_edge(input logic rst, input logic cs, input logic w,
                              input logic [1:0] a, input logic [15:0] d,
                              input logic [WIDTH-1:0] raw);
        logic [WIDTH-1:0] s2, acc, clr;
        logic             irq_next, all_diff, wr;
        int               n, sum;
        if (rst) begin
            m_stable = '0; m_chg = '0; m_mask = '0; m_cnt = '0; m_irq = 1'b0;
            raw_hist.delete();
            s2_hist.delete();
            return;
        end
        irq_next = |(m_chg & m_mask);
        raw_hist.push_back(raw);
        s2 = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size() - 3] : '0;
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        s2_hist.push_back(s2);
        if (s2_hist.size() > DB) void'(s2_hist.pop_front());
        acc = '0;
        if (s2_hist.size() == DB) begin
            for (int i = 0; i < WIDTH; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < s2_hist.size(); j++) begin
                    if (s2_hist[j][i] == m_stable[i]) all_diff = 1'b0;
                end
                acc[i] = all_diff;
            end
        end
        n  = $countones(acc);
        wr = cs && w;
        m_stable = m_stable ^ acc;
        sum = int'(m_cnt) + n;
        if (wr && a == 2'd3) m_cnt = 16'(n);
        else                 m_cnt = (sum > 65535) ? 16'hFFFF : 16'(sum);
        clr   = (wr && a == 2'd1) ? d[WIDTH-1:0] : '0;
        m_chg = (m_chg & ~clr) | acc;
        if (wr && a == 2'd2) m_mask = d[WIDTH-1:0];
        m_irq = irq_next;
    endtask

    task automatic cycle(input logic rst, input logic cs, input logic w,
                         input logic [1:0] a, input logic [15:0] d,
                         input logic [WIDTH-1:0] raw);
        exp_t e;
        is_reset  = rst;
        bus.isCS  = cs;
        bus.isW   = w;
        bus.addr  = a;
        bus.dR    = d;
        data      = raw;
        e.exp_z   = !(cs && !w && !rst);
        e.exp_val = model_read(a);
        e.exp_irq = m_irq;
        e.addr    = a;
        sb.push_back(e);
        @(posedge clk);
        model_edge(rst, cs, w, a, d, raw);
        #1;
    endtask

    task automatic hold(input int n, input logic [1:0] a, input logic [WIDTH-1:0] raw);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b0, a, 16'd0, raw);
    endtask

    task automatic read_all(input logic [WIDTH-1:0] raw);
        for (int a = 0; a < 4; a++) cycle(1'b0, 1'b1, 1'b0, 2'(a), 16'd0, raw);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.exp_z) begin
                tests++;
                if (dW !== 16'hzzzz) begin
                    fails++;
                    $display("FAIL dW_hiz: got %h expected zzzz at %0t", dW, $time);
                end
            end else begin
                check($sformatf("dW_addr%0d", mon_e.addr), dW, mon_e.exp_val);
            end
            check("irq", {15'd0, irq}, {15'd0, mon_e.exp_irq});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] raw;
        logic             r_rst, r_cs, r_w;
        logic [1:0]       r_a;

        is_reset = 1'b1; bus.isCS = 1'b0; bus.isW = 1'b0; bus.addr = '0; bus.dR = '0; data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with write attempts and reads during reset.
        cycle(1'b1, 1'b1, 1'b1, 2'd2, 16'hFFFF, '0);
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 16'd0, '0);
        read_all('0);

        // Single rising bit, DATA read every edge to pin the latency.
        hold(8, 2'd0, 16'h0001);
        read_all(16'h0001);

        // Short glitch on bit 3 must be rejected.
        hold(3, 2'd0, 16'h0009);
        hold(8, 2'd0, 16'h0001);
        read_all(16'h0001);

        // Mask/irq path, W1C clear, and set-wins-over-clear on one edge.
        cycle(1'b0, 1'b1, 1'b1, 2'd1, 16'hFFFF, 16'h0001);
        cycle(1'b0, 1'b1, 1'b1, 2'd2, 16'h0001, 16'h0001);
        hold(3, 2'd1, 16'h0001);
        hold(9, 2'd1, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 2'd1, 16'h0001, 16'h0000);
        hold(3, 2'd1, 16'h0000);
        hold(DB + 1, 2'd1, 16'h0001);
        cycle(1'b0, 1'b1, 1'b1, 2'd1, 16'h0001, 16'h0001);
        hold(3, 2'd1, 16'h0001);

        // All sixteen bits rising together, then drive CNT into saturation.
        hold(8, 2'd0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 2'd3, 16'h1234, 16'h0000);
        hold(8, 2'd3, 16'hFFFF);
        raw = 16'hFFFF;
        for (int it = 0; it < 5000 && m_cnt < 16'hFFF8; it++) begin
            raw = ~raw;
            hold(DB, 2'd3, raw);
        end
        for (int t = 0; t < 3; t++) begin
            raw = ~raw;
            hold(DB, 2'd3, raw);
        end
        raw = ~raw;
        for (int k = 0; k < DB; k++) cycle(1'b0, 1'b1, 1'b1, 2'd3, 16'd0, raw);
        hold(DB, 2'd3, raw);

        // Tri-state behaviour, ignored DATA write, MASK readback.
        cycle(1'b0, 1'b1, 1'b1, 2'd2, 16'hA5A5, raw);
        cycle(1'b0, 1'b1, 1'b0, 2'd2, 16'd0, raw);
        cycle(1'b0, 1'b0, 1'b0, 2'd2, 16'd0, raw);
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 16'hFFFF, raw);
        cycle(1'b0, 1'b1, 1'b1, 2'd0, 16'h5A5A, raw);
        read_all(raw);

        // Reset in the middle of a debounce, then release with data held.
        hold(8, 2'd0, 16'h0000);
        hold(4, 2'd0, 16'hFFFF);
        cycle(1'b1, 1'b1, 1'b1, 2'd2, 16'hFFFF, 16'hFFFF);
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 16'hFFFF);
        read_all(16'hFFFF);
        hold(8, 2'd0, 16'hFFFF);
        read_all(16'hFFFF);

        // Randomized traffic.
        raw = 16'h0000;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
            end
            r_rst = ($urandom_range(0, 99) == 0);
            r_cs  = ($urandom_range(0, 3) != 0);
            r_w   = ($urandom_range(0, 3) == 0);
            r_a   = 2'($urandom_range(0, 3));
            cycle(r_rst, r_cs, r_w, r_a, 16'($urandom), raw);
        end
        read_all(raw);

        @(negedge clk);
        #1;
        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
